// File: rtl/stage2_mag_if.sv
// Request/result bundle for stage2_mag: geometry terms in, conditioned magnitude and lever out.
interface stage2_mag_if #(
    parameter int W = 16
);
    logic         enable;
    logic [W-1:0] M;
    logic [W-1:0] N;
    logic [W-1:0] Lin;
    logic [W-1:0] L;
    logic [W-1:0] magMN;
    logic         clamped;
    logic         busy;
    logic         valid;

    modport master (
        output enable, M, N, Lin,
        input  L, magMN, clamped, busy, valid
    );

    modport slave (
        input  enable, M, N, Lin,
        output L, magMN, clamped, busy, valid
    );
endinterface

// File: rtl/stage2_mag.sv
// magMN = floor(sqrt(M^2 + N^2)) via a bit-serial restoring root, with L conditioned so L < magMN
// and magMN != 0 for the downstream divide/arcsin stage.
module stage2_mag #(
    parameter int W          = 16,
    parameter int SAT_MARGIN = 1
) (
    input  logic         clock,
    input  logic         rst,
    stage2_mag_if.slave  bus
);
    localparam int CW = $clog2(W) + 1;
    localparam int RW = W + 2;
    localparam int SW = W + 4;

    typedef enum logic [1:0] {IDLE, SQ, ROOT, FIN} state_t;

    state_t          state_reg;
    logic [W-1:0]    m_reg;
    logic [W-1:0]    n_reg;
    logic [W-1:0]    lin_reg;
    logic [2*W-1:0]  sum_reg;
    logic [RW-1:0]   rem_reg;
    logic [W-1:0]    root_reg;
    logic [CW-1:0]   cnt_reg;
    logic [W-1:0]    l_reg;
    logic [W-1:0]    mag_reg;
    logic            clamped_reg;
    logic            busy_reg;
    logic            valid_reg;

    logic [W-1:0]    abs_m;
    logic [W-1:0]    abs_n;
    logic [2*W-1:0]  abs_m_ext;
    logic [2*W-1:0]  abs_n_ext;
    logic [2*W-1:0]  sum_next;
    logic [SW-1:0]   rem_shift;
    logic [SW-1:0]   trial;
    logic            take_bit;
    logic [RW-1:0]   rem_next;
    logic [W-1:0]    root_next;
    logic [W-1:0]    margin;

    // Magnitudes are W-bit unsigned so the most negative input maps to 2^(W-1) without overflow.
    always_comb begin
        abs_m     = m_reg[W-1] ? (~m_reg + 1'b1) : m_reg;
        abs_n     = n_reg[W-1] ? (~n_reg + 1'b1) : n_reg;
        abs_m_ext = {{W{1'b0}}, abs_m};
        abs_n_ext = {{W{1'b0}}, abs_n};
        sum_next  = abs_m_ext * abs_m_ext + abs_n_ext * abs_n_ext;
    end

    // One restoring-root step: bring down the next two radicand bits, try appending a 1.
    always_comb begin
        rem_shift = {rem_reg, sum_reg[2*W-1:2*W-2]};
        trial     = {2'b00, root_reg, 2'b01};
        take_bit  = (rem_shift >= trial);
        rem_next  = take_bit ? RW'(rem_shift - trial) : RW'(rem_shift);
        root_next = {root_reg[W-2:0], take_bit};
        margin    = W'(SAT_MARGIN);
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            state_reg   <= IDLE;
            m_reg       <= '0;
            n_reg       <= '0;
            lin_reg     <= '0;
            sum_reg     <= '0;
            rem_reg     <= '0;
            root_reg    <= '0;
            cnt_reg     <= '0;
            l_reg       <= '0;
            mag_reg     <= '0;
            clamped_reg <= 1'b0;
            busy_reg    <= 1'b0;
            valid_reg   <= 1'b0;
        end else begin
            valid_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (bus.enable) begin
                        m_reg     <= bus.M;
                        n_reg     <= bus.N;
                        lin_reg   <= bus.Lin;
                        busy_reg  <= 1'b1;
                        state_reg <= SQ;
                    end
                end
                SQ: begin
                    sum_reg   <= sum_next;
                    rem_reg   <= '0;
                    root_reg  <= '0;
                    cnt_reg   <= '0;
                    state_reg <= ROOT;
                end
                ROOT: begin
                    sum_reg  <= {sum_reg[2*W-3:0], 2'b00};
                    rem_reg  <= rem_next;
                    root_reg <= root_next;
                    cnt_reg  <= cnt_reg + 1'b1;
                    if (cnt_reg == CW'(W - 1)) begin
                        state_reg <= FIN;
                    end
                end
                FIN: begin
                    if (root_reg == '0) begin
                        mag_reg     <= W'(1);
                        l_reg       <= '0;
                        clamped_reg <= 1'b1;
                    end else if (root_reg <= margin) begin
                        mag_reg     <= root_reg;
                        l_reg       <= '0;
                        clamped_reg <= (lin_reg != '0);
                    end else if (lin_reg > root_reg - margin) begin
                        mag_reg     <= root_reg;
                        l_reg       <= root_reg - margin;
                        clamped_reg <= 1'b1;
                    end else begin
                        mag_reg     <= root_reg;
                        l_reg       <= lin_reg;
                        clamped_reg <= 1'b0;
                    end
                    valid_reg <= 1'b1;
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign bus.L       = l_reg;
    assign bus.magMN   = mag_reg;
    assign bus.clamped = clamped_reg;
    assign bus.busy    = busy_reg;
    assign bus.valid   = valid_reg;
endmodule
